// File: rtl/ddr2_axi_rw_arbiter.sv
// ddr2_axi_rw_arbiter
// Shares the DDR2 controller's single AXI slave port between the write burst
// engine (AW/W/B) and the read burst engine (AR/R). One burst owns the port at
// a time; the grant is held until the burst completes (B handshake for writes,
// last R beat for reads). Fixed priority with a starvation limit picks the side
// when both request together. Write beats are counted against awlen.
module ddr2_axi_rw_arbiter #(
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 32,
  parameter int PRIO_WR      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  // upstream write side
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic                  s_wlast,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  // upstream read side
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  s_rlast,
  // downstream to DDR2 controller
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [7:0]            m_awlen,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wlast,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rlast,
  // status
  output logic                  grant_wr,
  output logic                  grant_rd,
  output logic                  err_wlen
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_DATA = 3'd5
  } state_t;

  localparam logic       PREF_WR    = (PRIO_WR != 0);
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

  state_t     state_r;
  state_t     state_s;
  logic [7:0] starve_cnt_r;
  logic [7:0] starve_cnt_s;
  logic [8:0] beat_cnt_r;
  logic [7:0] awlen_r;
  logic       err_wlen_r;

  logic go_wr_s;
  logic go_rd_s;
  logic starve_hit_s;
  logic pref_go_s;
  logic other_go_s;
  logic other_valid_s;
  logic aw_hs_s;
  logic w_hs_s;
  logic b_hs_s;
  logic ar_hs_s;
  logic r_hs_s;

  // Handshakes only count on the channel that currently owns the port.
  assign aw_hs_s = (state_r == ST_WR_ADDR) && s_awvalid && m_awready;
  assign w_hs_s  = (state_r == ST_WR_DATA) && s_wvalid && m_wready;
  assign b_hs_s  = (state_r == ST_WR_RESP) && m_bvalid && s_bready;
  assign ar_hs_s = (state_r == ST_RD_ADDR) && s_arvalid && m_arready;
  assign r_hs_s  = (state_r == ST_RD_DATA) && m_rvalid && s_rready;

  assign starve_hit_s  = (starve_cnt_r >= STARVE_LIM);
  assign other_valid_s = PREF_WR ? s_arvalid : s_awvalid;
  assign pref_go_s     = PREF_WR ? go_wr_s : go_rd_s;
  assign other_go_s    = PREF_WR ? go_rd_s : go_wr_s;

  // Arbitration decision, taken only in IDLE once DDR2 init has finished.
  always_comb begin
    go_wr_s = 1'b0;
    go_rd_s = 1'b0;
    if ((state_r == ST_IDLE) && init_end) begin
      if (s_awvalid && s_arvalid) begin
        if (starve_hit_s) begin
          go_wr_s = ~PREF_WR;
          go_rd_s = PREF_WR;
        end else begin
          go_wr_s = PREF_WR;
          go_rd_s = ~PREF_WR;
        end
      end else begin
        go_wr_s = s_awvalid;
        go_rd_s = s_arvalid;
      end
    end else begin
      go_wr_s = 1'b0;
      go_rd_s = 1'b0;
    end
  end

  // Starvation counter: counts preferred wins over a waiting other side.
  always_comb begin
    starve_cnt_s = starve_cnt_r;
    if (pref_go_s && other_valid_s) begin
      if (starve_cnt_r != 8'd255) begin
        starve_cnt_s = starve_cnt_r + 8'd1;
      end else begin
        starve_cnt_s = starve_cnt_r;
      end
    end else if (other_go_s) begin
      starve_cnt_s = 8'd0;
    end else begin
      starve_cnt_s = starve_cnt_r;
    end
  end

  // Next-state logic: each grant is held until its burst completes.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go_wr_s) begin
          state_s = ST_WR_ADDR;
        end else if (go_rd_s) begin
          state_s = ST_RD_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR_ADDR: begin
        if (aw_hs_s) state_s = ST_WR_DATA;
        else         state_s = ST_WR_ADDR;
      end
      ST_WR_DATA: begin
        if (w_hs_s && s_wlast) state_s = ST_WR_RESP;
        else                   state_s = ST_WR_DATA;
      end
      ST_WR_RESP: begin
        if (b_hs_s) state_s = ST_IDLE;
        else        state_s = ST_WR_RESP;
      end
      ST_RD_ADDR: begin
        if (ar_hs_s) state_s = ST_RD_DATA;
        else         state_s = ST_RD_ADDR;
      end
      ST_RD_DATA: begin
        if (r_hs_s && m_rlast) state_s = ST_IDLE;
        else                   state_s = ST_RD_DATA;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State and starvation counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      starve_cnt_r <= 8'd0;
    end else begin
      state_r      <= state_s;
      starve_cnt_r <= starve_cnt_s;
    end
  end

  // Write beat counting and sticky length-error flag (cleared only by rst).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_r <= 9'd0;
      awlen_r    <= 8'd0;
      err_wlen_r <= 1'b0;
    end else if (aw_hs_s) begin
      awlen_r    <= s_awlen;
      beat_cnt_r <= 9'd0;
    end else if (w_hs_s) begin
      beat_cnt_r <= beat_cnt_r + 9'd1;
      if (s_wlast && ((beat_cnt_r + 9'd1) != ({1'b0, awlen_r} + 9'd1))) begin
        err_wlen_r <= 1'b1;
      end
    end
  end

  // Channel routing: only the channel of the current state is passed through.
  always_comb begin
    s_awready = 1'b0;
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_awlen   = 8'd0;
    s_wready  = 1'b0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wlast   = 1'b0;
    s_bvalid  = 1'b0;
    m_bready  = 1'b0;
    s_arready = 1'b0;
    m_arvalid = 1'b0;
    m_araddr  = '0;
    m_arlen   = 8'd0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rlast   = 1'b0;
    m_rready  = 1'b0;
    case (state_r)
      ST_WR_ADDR: begin
        m_awvalid = s_awvalid;
        m_awaddr  = s_awaddr;
        m_awlen   = s_awlen;
        s_awready = m_awready;
      end
      ST_WR_DATA: begin
        m_wvalid = s_wvalid;
        m_wdata  = s_wdata;
        m_wlast  = s_wlast;
        s_wready = m_wready;
      end
      ST_WR_RESP: begin
        s_bvalid = m_bvalid;
        m_bready = s_bready;
      end
      ST_RD_ADDR: begin
        m_arvalid = s_arvalid;
        m_araddr  = s_araddr;
        m_arlen   = s_arlen;
        s_arready = m_arready;
      end
      ST_RD_DATA: begin
        s_rvalid = m_rvalid;
        s_rdata  = m_rdata;
        s_rlast  = m_rlast;
        m_rready = s_rready;
      end
      default: begin
        s_awready = 1'b0;
      end
    endcase
  end

  // Status outputs decoded from registered state.
  always_comb begin
    grant_wr = (state_r == ST_WR_ADDR) || (state_r == ST_WR_DATA) || (state_r == ST_WR_RESP);
    grant_rd = (state_r == ST_RD_ADDR) || (state_r == ST_RD_DATA);
    err_wlen = err_wlen_r;
  end

endmodule

// File: tb/tb_ddr2_axi_rw_arbiter.sv
// Directed testbench for ddr2_axi_rw_arbiter.
// dut:  PRIO_WR=1, STARVE_LIMIT=4 with a simple always-ready controller model.
// dut2: PRIO_WR=0, STARVE_LIMIT=1 with every request and response tied high.
module tb_ddr2_axi_rw_arbiter;

  logic        clk;
  logic        rst;
  logic        init_end;
  logic        s_awvalid, s_awready;
  logic [25:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic        s_wlast;
  logic        s_bvalid, s_bready;
  logic        s_arvalid, s_arready;
  logic [25:0] s_araddr;
  logic [7:0]  s_arlen;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic        s_rlast;
  logic        m_awvalid;
  logic [25:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic        m_wvalid;
  logic [31:0] m_wdata;
  logic        m_wlast;
  logic        m_bready;
  logic        m_arvalid;
  logic [25:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_rready;
  logic [31:0] m_rdata;
  logic        m_rlast;
  logic        grant_wr, grant_rd, err_wlen;

  // controller-side model state
  logic [7:0]  rd_beat, rd_len;
  int          fwd_cnt, data_err;

  // second instance
  logic        init_end2;
  logic        d2_s_awready, d2_s_wready, d2_s_bvalid, d2_s_arready, d2_s_rvalid, d2_s_rlast;
  logic [31:0] d2_s_rdata, d2_m_wdata;
  logic        d2_m_awvalid, d2_m_wvalid, d2_m_wlast, d2_m_bready, d2_m_arvalid, d2_m_rready;
  logic [25:0] d2_m_awaddr, d2_m_araddr;
  logic [7:0]  d2_m_awlen, d2_m_arlen;
  logic        d2_grant_wr, d2_grant_rd, d2_err_wlen;

  int checks = 0;
  int errors = 0;

  ddr2_axi_rw_arbiter #(.ADDR_WIDTH(26), .DATA_WIDTH(32), .PRIO_WR(1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .init_end(init_end),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast),
    .m_awvalid(m_awvalid), .m_awready(1'b1), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(1'b1), .m_wdata(m_wdata), .m_wlast(m_wlast),
    .m_bvalid(1'b1), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(1'b1), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(1'b1), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .grant_wr(grant_wr), .grant_rd(grant_rd), .err_wlen(err_wlen)
  );

  ddr2_axi_rw_arbiter #(.ADDR_WIDTH(26), .DATA_WIDTH(32), .PRIO_WR(0), .STARVE_LIMIT(1)) dut2 (
    .clk(clk), .rst(rst), .init_end(init_end2),
    .s_awvalid(1'b1), .s_awready(d2_s_awready), .s_awaddr(26'h0000040), .s_awlen(8'd0),
    .s_wvalid(1'b1), .s_wready(d2_s_wready), .s_wdata(32'h0000_00A5), .s_wlast(1'b1),
    .s_bvalid(d2_s_bvalid), .s_bready(1'b1),
    .s_arvalid(1'b1), .s_arready(d2_s_arready), .s_araddr(26'h0000080), .s_arlen(8'd0),
    .s_rvalid(d2_s_rvalid), .s_rready(1'b1), .s_rdata(d2_s_rdata), .s_rlast(d2_s_rlast),
    .m_awvalid(d2_m_awvalid), .m_awready(1'b1), .m_awaddr(d2_m_awaddr), .m_awlen(d2_m_awlen),
    .m_wvalid(d2_m_wvalid), .m_wready(1'b1), .m_wdata(d2_m_wdata), .m_wlast(d2_m_wlast),
    .m_bvalid(1'b1), .m_bready(d2_m_bready),
    .m_arvalid(d2_m_arvalid), .m_arready(1'b1), .m_araddr(d2_m_araddr), .m_arlen(d2_m_arlen),
    .m_rvalid(1'b1), .m_rready(d2_m_rready), .m_rdata(32'h0000_005A), .m_rlast(1'b1),
    .grant_wr(d2_grant_wr), .grant_rd(d2_grant_rd), .err_wlen(d2_err_wlen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data source: data = beat index, last beat when index reaches arlen.
  assign m_rdata = {24'd0, rd_beat};
  assign m_rlast = (rd_beat == rd_len);

  // Controller-side read beat tracking.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_beat <= 8'd0;
      rd_len  <= 8'd0;
    end else if (m_arvalid) begin
      rd_len  <= m_arlen;
      rd_beat <= 8'd0;
    end else if (m_rvalid_hs()) begin
      rd_beat <= rd_beat + 8'd1;
    end
  end

  function automatic logic m_rvalid_hs();
    return m_rready;
  endfunction

  // Forwarded write beat counter; data of beat k must equal k.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_cnt  <= 0;
      data_err <= 0;
    end else if (m_awvalid) begin
      fwd_cnt <= 0;
    end else if (m_wvalid) begin
      fwd_cnt <= fwd_cnt + 1;
      if (m_wdata != 32'(fwd_cnt)) data_err <= data_err + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic hs_now(input int ch);
    case (ch)
      0: return s_awvalid && s_awready;
      1: return s_wvalid && s_wready;
      2: return s_bvalid && s_bready;
      3: return s_arvalid && s_arready;
      4: return s_rvalid && s_rready;
      default: return 1'b0;
    endcase
  endfunction

  // Wait (bounded) until the handshake is visible, then cross the clock edge.
  task automatic wait_hs(input int ch, input string tag);
    int n = 0;
    while (!hs_now(ch) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(hs_now(ch)), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_burst(input logic [25:0] addr, input logic [7:0] len, input int nbeats,
                             input logic exp_err);
    s_awvalid = 1'b1;
    s_awaddr  = addr;
    s_awlen   = len;
    wait_hs(0, "aw_hs");
    s_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      s_wvalid = 1'b1;
      s_wdata  = 32'(i);
      s_wlast  = (i == nbeats - 1);
      wait_hs(1, "w_hs");
    end
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
    check_val("err_wlen_after_last", 32'(err_wlen), 32'(exp_err));
    wait_hs(2, "b_hs");
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_wlast = 1'b0; s_arvalid = 1'b0;
    s_awlen = 8'd0; s_arlen = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Record which side (1 = write, 0 = read) is granted for n consecutive bursts.
  task automatic collect_grants(input int which, input int n, output logic [9:0] seq, output int got);
    logic pw = 1'b0;
    logic pr = 1'b0;
    logic gw, gr;
    seq = 10'd0;
    got = 0;
    for (int c = 0; c < 400 && got < n; c++) begin
      @(negedge clk);
      gw = (which == 0) ? grant_wr : d2_grant_wr;
      gr = (which == 0) ? grant_rd : d2_grant_rd;
      if (gw && !pw) begin
        seq[got] = 1'b1;
        got++;
      end else if (gr && !pr) begin
        seq[got] = 1'b0;
        got++;
      end
      pw = gw;
      pr = gr;
    end
  endtask

  initial begin
    logic [9:0] seq;
    logic [9:0] exp_seq1;
    logic [3:0] exp_seq2;
    int         got;
    int         viol;

    rst = 1'b1; init_end = 1'b0; init_end2 = 1'b0;
    s_awvalid = 1'b0; s_awaddr = 26'd0; s_awlen = 8'd0;
    s_wvalid = 1'b0; s_wdata = 32'd0; s_wlast = 1'b0; s_bready = 1'b1;
    s_arvalid = 1'b0; s_araddr = 26'd0; s_arlen = 8'd0; s_rready = 1'b1;

    // reset state
    @(posedge clk); #1;
    check_val("reset_grants_err", {29'd0, grant_wr, grant_rd, err_wlen}, 32'd0);
    check_val("reset_valids_readys",
              {21'd0, m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid, s_awready,
               s_wready, s_arready, m_bready, m_rready, s_rlast}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // init_end low: requests pending for 20 cycles, nothing granted
    s_awvalid = 1'b1; s_arvalid = 1'b1; s_wvalid = 1'b1; s_wlast = 1'b1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_awvalid || m_arvalid || m_wvalid || grant_wr || grant_rd || s_awready || s_arready)
        viol++;
    end
    check_val("init_low_no_grant", 32'(viol), 32'd0);
    init_end = 1'b1;
    @(posedge clk); #1;
    check_val("init_rise_grant_wr", {30'd0, grant_wr, grant_rd}, 32'd2);
    check_val("init_rise_m_awvalid", 32'(m_awvalid), 32'd1);
    pulse_rst();

    // write-only 128-beat burst with latency and stall checks
    s_awvalid = 1'b1; s_awaddr = 26'h012_3450; s_awlen = 8'd127;
    s_wvalid = 1'b1; s_wdata = 32'hDEAD_BEEF; s_wlast = 1'b0;
    check_val("wr_latency_not_same_cycle", 32'(m_awvalid), 32'd0);
    @(posedge clk); #1;
    check_val("wr_latency_next_cycle", {30'd0, m_awvalid, grant_wr}, 32'd3);
    check_val("wr_m_awaddr", {6'd0, m_awaddr}, 32'h0012_3450);
    check_val("wr_m_awlen", {24'd0, m_awlen}, 32'd127);
    check_val("w_stalled_before_aw", {30'd0, s_wready, m_wvalid}, 32'd0);
    write_burst(26'h012_3450, 8'd127, 128, 1'b0);
    check_val("wr128_fwd_beats", 32'(fwd_cnt), 32'd128);
    check_val("wr128_fwd_data_errs", 32'(data_err), 32'd0);
    check_val("wr128_back_idle", {30'd0, grant_wr, grant_rd}, 32'd0);

    // short burst: awlen=7 but wlast on 6th beat, then a clean burst keeps the flag
    write_burst(26'h000_0800, 8'd7, 6, 1'b1);
    write_burst(26'h000_0900, 8'd3, 4, 1'b1);
    check_val("err_wlen_sticky", 32'(err_wlen), 32'd1);
    pulse_rst();
    check_val("err_wlen_cleared_by_rst", 32'(err_wlen), 32'd0);

    // 128-beat read, reset asserted while beat 50 is pending
    s_arvalid = 1'b1; s_araddr = 26'h020_0000; s_arlen = 8'd127;
    wait_hs(3, "ar_hs");
    s_arvalid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i % 10 == 0) check_val("rd_data", s_rdata, 32'(i));
      wait_hs(4, "r_hs");
    end
    check_val("rd_beat50_owned", {30'd0, grant_rd, s_rvalid}, 32'd3);
    rst = 1'b1;
    #1;
    check_val("async_rst_outputs",
              {26'd0, grant_rd, s_rvalid, m_rready, s_rlast, grant_wr, m_arvalid}, 32'd0);
    check_val("async_rst_rdata", s_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    write_burst(26'h000_0A00, 8'd3, 4, 1'b0);

    // both sides pending continuously, write preferred, limit 4
    pulse_rst();
    s_awvalid = 1'b1; s_arvalid = 1'b1; s_awlen = 8'd0; s_arlen = 8'd0;
    s_wvalid = 1'b1; s_wlast = 1'b1;
    collect_grants(0, 10, seq, got);
    exp_seq1 = 10'b01111_01111;
    check_val("prio_wr_grant_count", 32'(got), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check_val($sformatf("prio_wr_seq%0d", i), 32'(seq[i]), 32'(exp_seq1[i]));
    end
    pulse_rst();

    // read preferred, limit 1: strict alternation starting with read
    init_end2 = 1'b1;
    collect_grants(1, 4, seq, got);
    exp_seq2 = 4'b1010;
    check_val("prio_rd_grant_count", 32'(got), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("prio_rd_seq%0d", i), 32'(seq[i]), 32'(exp_seq2[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr2_axi_rw_arbiter.md
Name: ddr2_axi_rw_arbiter

Overview:
- Shares the single AXI slave port of the DDR2 controller between the write burst engine (aw/w/b) and the read burst engine (ar/r) of the user-side master.
- Exactly one burst is in flight at a time. Each grant is held until that burst fully completes: write ends at the B handshake, read ends at the R beat with rlast.
- Arbitration is fixed-priority with a starvation limit. Write-side beat counting flags length errors.

Parameters:
ADDR_WIDTH, 26, AXI address width
DATA_WIDTH, 32, AXI data width
PRIO_WR, 1, 1 = write is preferred side, 0 = read preferred
STARVE_LIMIT, 4, consecutive preferred grants allowed while other side waits (legal range 1..255)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
init_end  in  1  DDR2 init complete; no grant while low
s_awvalid/s_awready  in/out  1/1  upstream AW handshake
s_awaddr  in  ADDR_WIDTH  upstream write address
s_awlen  in  8  upstream write burst length-1
s_wvalid/s_wready  in/out  1/1  upstream W handshake
s_wdata  in  DATA_WIDTH  upstream write data
s_wlast  in  1  upstream last write beat
s_bvalid/s_bready  out/in  1/1  upstream B handshake
s_arvalid/s_arready  in/out  1/1  upstream AR handshake
s_araddr  in  ADDR_WIDTH  upstream read address
s_arlen  in  8  upstream read burst length-1
s_rvalid/s_rready  out/in  1/1  upstream R handshake
s_rdata  out  DATA_WIDTH  upstream read data
s_rlast  out  1  upstream last read beat
m_* (same set, opposite directions)  -  -  downstream to DDR2 controller
grant_wr  out  1  write burst owns the port
grant_rd  out  1  read burst owns the port
err_wlen  out  1  sticky: wlast beat count != awlen+1

Behaviour:
- Reset: state IDLE. All m_*valid, s_*ready, m_bready, m_rready, s_bvalid, s_rvalid, grant_*, err_wlen = 0. starve_cnt = 0, beat_cnt = 0.
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA. grant_wr = state in {WR_*}; grant_rd = state in {RD_*}.
- IDLE: all channels gated to 0. Decision is taken only when init_end = 1.
  - Only s_awvalid high -> WR_ADDR.
  - Only s_arvalid high -> RD_ADDR.
  - Both high -> the preferred side, unless starve_cnt >= STARVE_LIMIT, in which case the other side.
- starve_cnt (8-bit, saturating at 255):
  - Increments when the preferred side is granted while the other valid is high.
  - Clears when the non-preferred side is granted.
  - Holds otherwise.
- Grant latency: a valid first seen in IDLE at cycle N appears on the m_ side at N+1. One IDLE bubble cycle follows every completed burst.
- WR_ADDR: m_aw* = s_aw* and s_awready = m_awready (combinational pass-through). On handshake, capture awlen, clear beat_cnt, go to WR_DATA.
- WR_DATA: W channel pass-through; beat_cnt increments on each W handshake.
  - On the handshake with wlast: set err_wlen if beat_cnt+1 != awlen+1, then go to WR_RESP.
  - A W beat presented before the AW handshake is stalled (s_wready = 0).
- WR_RESP: B channel pass-through. Handshake -> IDLE.
- RD_ADDR: AR pass-through. Handshake -> RD_DATA.
- RD_DATA: R channel pass-through. Handshake with m_rlast -> IDLE. No read beat count check.
- Ungranted channels: m_valid = 0 and s_ready = 0, regardless of upstream valid.
- An upstream valid held across the IDLE cycle is legal. It must not be dropped or duplicated.
- init_end falling mid-burst: the current burst completes; the next grant is blocked.
- Reset mid-burst: immediate return to IDLE with reset values. err_wlen clears only on rst.

Test Plan:
- Write-only: 1 aw (awlen=127) plus 128 W beats, controller ready -> m_awvalid one cycle after s_awvalid; 128 beats forwarded; WR_RESP; IDLE; err_wlen = 0.
- Both pending continuously, PRIO_WR=1, STARVE_LIMIT=4 -> grant sequence W,W,W,W,R,W,W,W,W,R.
- PRIO_WR=0, STARVE_LIMIT=1, both pending -> strict alternation R,W,R,W.
- init_end = 0 with s_awvalid and s_arvalid high for 20 cycles -> no m_ valid and no grant. Raise init_end -> grant on the next cycle.
- awlen=7 with wlast on the 6th beat -> err_wlen = 1 after that beat, stays 1 through later clean bursts, cleared by rst.
- Assert rst during RD_DATA beat 50 of 128 -> same-cycle (asynchronous) return of all outputs to 0, state IDLE. A subsequent write is granted normally.
